// File: rtl/quantizer_array_if.sv
// Stream bundle for quantizer_array: input beats (accumulators + channel
// base + activation mode) and output beats (saturated activations).
//   in_valid/in_ready/data_in/ch_base/act_mode : upstream beat handshake
//   out_valid/out_ready/data_out               : downstream beat handshake
//   master : the side that produces input beats and consumes outputs
//   slave  : the quantizer itself
interface quantizer_array_if #(
    parameter int LANES = 4,
    parameter int IN_W  = 32,
    parameter int OUT_W = 8,
    parameter int CH_W  = 6
);
    logic                   in_valid;
    logic                   in_ready;
    logic [LANES*IN_W-1:0]  data_in;
    logic [CH_W-1:0]        ch_base;
    logic [1:0]             act_mode;
    logic                   out_valid;
    logic                   out_ready;
    logic [LANES*OUT_W-1:0] data_out;

    modport master (
        output in_valid, data_in, ch_base, act_mode, out_ready,
        input  in_ready, out_valid, data_out
    );

    modport slave (
        input  in_valid, data_in, ch_base, act_mode, out_ready,
        output in_ready, out_valid, data_out
    );
endinterface

// File: rtl/quantizer_array.sv
// Multi-lane requantizer: per-channel bias, multiplier, rounding shift,
// activation and saturation in a 4-stage valid/ready pipeline.
//   clk, rst        : clock, synchronous active-low reset
//   io (slave)      : input/output beat streams
//   cfg_we/addr/M/n/bias : per-channel table write port
//   sat_clr, sat_cnt     : saturated-lane counter (sticky at max)
module quantizer_array #(
    parameter  int LANES  = 4,
    parameter  int IN_W   = 32,
    parameter  int OUT_W  = 8,
    parameter  int NUM_CH = 64,
    parameter  int CNT_W  = 16,
    localparam int CH_W   = $clog2(NUM_CH)
) (
    input  logic             clk,
    input  logic             rst,
    quantizer_array_if.slave io,
    input  logic             cfg_we,
    input  logic [CH_W-1:0]  cfg_addr,
    input  logic [31:0]      cfg_M,
    input  logic [4:0]       cfg_n,
    input  logic [31:0]      cfg_bias,
    input  logic             sat_clr,
    output logic [CNT_W-1:0] sat_cnt
);
    // Sum is one bit wider than the wider operand so it never overflows.
    localparam int S_W  = ((IN_W > 32) ? IN_W : 32) + 1;
    localparam int P_W  = S_W + 33;
    localparam int SN_W = $clog2(LANES + 1);
    localparam logic signed [P_W-1:0] QMAX = (2 ** (OUT_W - 1)) - 1;
    localparam logic signed [P_W-1:0] QMIN = -(2 ** (OUT_W - 1));

    logic en;
    assign en = !io.out_valid || io.out_ready;
    assign io.in_ready = en;

    // Per-channel configuration table
    logic        [31:0] m_tab    [NUM_CH];
    logic        [4:0]  n_tab    [NUM_CH];
    logic signed [31:0] bias_tab [NUM_CH];

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                m_tab[c]    <= '0;
                n_tab[c]    <= '0;
                bias_tab[c] <= '0;
            end
        end else if (cfg_we) begin
            m_tab[cfg_addr]    <= cfg_M;
            n_tab[cfg_addr]    <= cfg_n;
            bias_tab[cfg_addr] <= cfg_bias;
        end
    end

    // Stage 1: table lookup and bias add
    logic [CH_W-1:0]   ch   [LANES];
    logic              v1;
    logic [1:0]        mode1;
    logic signed [S_W-1:0] s1 [LANES];
    logic [31:0]       m1   [LANES];
    logic [4:0]        n1   [LANES];

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            ch[i] = io.ch_base + CH_W'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            v1    <= 1'b0;
            mode1 <= '0;
            for (int i = 0; i < LANES; i++) begin
                s1[i] <= '0;
                m1[i] <= '0;
                n1[i] <= '0;
            end
        end else if (en) begin
            v1 <= io.in_valid;
            // Reserved mode behaves as pass-through.
            mode1 <= (io.act_mode == 2'd3) ? 2'd0 : io.act_mode;
            for (int i = 0; i < LANES; i++) begin
                s1[i] <= S_W'($signed(io.data_in[i*IN_W +: IN_W]))
                       + S_W'(bias_tab[ch[i]]);
                m1[i] <= m_tab[ch[i]];
                n1[i] <= n_tab[ch[i]];
            end
        end
    end

    // Stage 2: signed sum times unsigned multiplier
    logic              v2;
    logic [1:0]        mode2;
    logic signed [P_W-1:0] p2 [LANES];
    logic [4:0]        n2   [LANES];
    logic [LANES-1:0]  neg2;

    always_ff @(posedge clk) begin
        if (!rst) begin
            v2    <= 1'b0;
            mode2 <= '0;
            neg2  <= '0;
            for (int i = 0; i < LANES; i++) begin
                p2[i] <= '0;
                n2[i] <= '0;
            end
        end else if (en) begin
            v2    <= v1;
            mode2 <= mode1;
            for (int i = 0; i < LANES; i++) begin
                p2[i]   <= s1[i] * $signed({1'b0, m1[i]});
                n2[i]   <= n1[i];
                neg2[i] <= s1[i][S_W-1];
            end
        end
    end

    // Stage 3: rounding shift and activation
    logic [5:0]            k3    [LANES];
    logic [P_W-1:0]        half3 [LANES];
    logic signed [P_W-1:0] rnd3  [LANES];
    logic signed [P_W-1:0] q3n   [LANES];
    logic                  v3;
    logic signed [P_W-1:0] q3    [LANES];

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            k3[i] = {1'b0, n2[i]};
            // Leaky slope of 1/8 folds into three extra shift bits.
            if (mode2 == 2'd1 && neg2[i]) begin
                k3[i] = k3[i] + 6'd3;
            end
            half3[i] = P_W'(1) << (k3[i] - 6'd1);
            rnd3[i]  = p2[i] + $signed(half3[i]);
            if (k3[i] == 6'd0) begin
                q3n[i] = p2[i];
            end else begin
                q3n[i] = rnd3[i] >>> k3[i];
            end
            if (mode2 == 2'd2 && neg2[i]) begin
                q3n[i] = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            v3 <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                q3[i] <= '0;
            end
        end else if (en) begin
            v3 <= v2;
            for (int i = 0; i < LANES; i++) begin
                q3[i] <= q3n[i];
            end
        end
    end

    // Stage 4: saturate, output register, saturation counter
    logic [OUT_W-1:0]       clip [LANES];
    logic [LANES-1:0]       sat;
    logic [SN_W-1:0]        sat_num;
    logic [CNT_W:0]         sat_sum;
    logic                   out_valid_q;
    logic [LANES*OUT_W-1:0] data_out_q;
    logic [CNT_W-1:0]       sat_cnt_q;

    always_comb begin
        sat_num = '0;
        for (int i = 0; i < LANES; i++) begin
            sat[i] = 1'b1;
            if (q3[i] > QMAX) begin
                clip[i] = QMAX[OUT_W-1:0];
            end else if (q3[i] < QMIN) begin
                clip[i] = QMIN[OUT_W-1:0];
            end else begin
                clip[i] = q3[i][OUT_W-1:0];
                sat[i]  = 1'b0;
            end
            sat_num = sat_num + SN_W'(sat[i]);
        end
        sat_sum = {1'b0, sat_cnt_q} + (CNT_W+1)'(sat_num);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
            data_out_q  <= '0;
            sat_cnt_q   <= '0;
        end else begin
            if (en) begin
                out_valid_q <= v3;
                for (int i = 0; i < LANES; i++) begin
                    data_out_q[i*OUT_W +: OUT_W] <= clip[i];
                end
            end
            if (sat_clr) begin
                sat_cnt_q <= '0;
            end else if (en && v3) begin
                sat_cnt_q <= sat_sum[CNT_W] ? '1 : sat_sum[CNT_W-1:0];
            end
        end
    end

    assign io.out_valid = out_valid_q;
    assign io.data_out  = data_out_q;
    assign sat_cnt      = sat_cnt_q;
endmodule
